// File: rtl/seq_mult_param.sv
// seq_mult_param: parametrised shift-add multiplier with a valid/ack handshake.
// Signed operands are reduced to magnitudes. The unsigned product is built one
// multiplier bit per cycle. The sign is applied once, in FIX, so that a single
// unsigned datapath serves both modes.
module seq_mult_param #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iValid_Data,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iData_A,
  input  logic [WIDTH-1:0]     iData_B,
  input  logic                 iAck,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oProduct
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state_q,   state_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [2*WIDTH-1:0] mcand_q,   mcand_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mreg_q,    mreg_d;
  logic [CW-1:0]      count_q,   count_d;
  logic               sign_q,    sign_d;

  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] accSum;
  logic               lastIter;

  // Operand magnitudes, the conditional partial-product add and the loop-exit test
  always_comb begin
    magA     = (iSigned && iData_A[WIDTH-1]) ? -iData_A : iData_A;
    magB     = (iSigned && iData_B[WIDTH-1]) ? -iData_B : iData_B;
    accSum   = mreg_q[0] ? (acc_q + mcand_q) : acc_q;
    lastIter = (count_q == CW'(WIDTH - 1)) ||
               (EARLY_EXIT && (mreg_q[WIDTH-1:1] == '0));
  end

  // Control sequencing and datapath next-state; every register holds unless its state updates it
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    mreg_d    = mreg_q;
    count_d   = count_q;
    sign_d    = sign_q;
    case (state_q)
      IDLE: begin
        if (iValid_Data) begin
          mcand_d = {{WIDTH{1'b0}}, magA};
          mreg_d  = magB;
          acc_d   = '0;
          count_d = '0;
          sign_d  = iSigned & (iData_A[WIDTH-1] ^ iData_B[WIDTH-1]);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = accSum;
        mcand_d = mcand_q << 1;
        mreg_d  = mreg_q >> 1;
        count_d = count_q + CW'(1);
        if (lastIter) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d = sign_q ? -acc_q : acc_q;
        state_d   = DONE;
      end
      DONE: begin
        if (iAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears the visible result
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      mreg_q    <= '0;
      count_q   <= '0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      mreg_q    <= mreg_d;
      count_q   <= count_d;
      sign_q    <= sign_d;
    end
  end

  // Status outputs decode straight from the state register
  always_comb begin
    oBusy    = (state_q == CALC) || (state_q == FIX);
    oDone    = (state_q == DONE);
    oProduct = product_q;
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: two 32-bit instances, one running every iteration and one
// exiting early, checked each cycle against an arithmetic reference model.
module tb_seq_mult_param;

  localparam int W = 32;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [1:0]    iValid;
  logic [1:0]    iAck;
  logic          iSigned;
  logic [W-1:0]  iData_A;
  logic [W-1:0]  iData_B;
  logic [1:0]    oBusy;
  logic [1:0]    oDone;
  logic [2*W-1:0] prod0;
  logic [2*W-1:0] prod1;

  int checks   = 0;
  int failures = 0;

  int             mCnt  [2];
  bit             mDone [2];
  logic [2*W-1:0] mProd [2];
  logic [2*W-1:0] mPend [2];

  seq_mult_param #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
    .Clock(Clock), .Reset(Reset), .iValid_Data(iValid[0]), .iSigned(iSigned),
    .iData_A(iData_A), .iData_B(iData_B), .iAck(iAck[0]),
    .oBusy(oBusy[0]), .oDone(oDone[0]), .oProduct(prod0));

  seq_mult_param #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
    .Clock(Clock), .Reset(Reset), .iValid_Data(iValid[1]), .iSigned(iSigned),
    .iData_A(iData_A), .iData_B(iData_B), .iAck(iAck[1]),
    .oBusy(oBusy[1]), .oDone(oDone[1]), .oProduct(prod1));

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 Clock = ~Clock;

  function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic int latencyOf(input logic [W-1:0] b, input logic s, input int ee);
    logic [W-1:0] m;
    int iters;
    if (ee == 0) return W + 1;
    m = (s && b[W-1]) ? -b : b;
    iters = 1;
    for (int i = 0; i < W; i++) if (m[i]) iters = i + 1;
    return iters + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [2*W-1:0] act,
                             input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts the expected latency down from each accept, publishes the product on completion
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 2; k++) begin
        mCnt[k]  <= 0;
        mDone[k] <= 1'b0;
        mProd[k] <= '0;
        mPend[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mDone[k]) begin
          if (iAck[k]) mDone[k] <= 1'b0;
        end else if (mCnt[k] > 0) begin
          if (mCnt[k] == 1) begin
            mDone[k] <= 1'b1;
            mProd[k] <= mPend[k];
          end
          mCnt[k] <= mCnt[k] - 1;
        end else if (iValid[k]) begin
          mCnt[k]  <= latencyOf(iData_B, iSigned, k);
          mPend[k] <= refProduct(iData_A, iData_B, iSigned);
        end
      end
    end
  end

  // Every falling edge out of reset, compare both instances against the model
  always @(negedge Clock) begin
    if (!Reset) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("dut%0d busy", k), {63'b0, oBusy[k]}, {63'b0, (mCnt[k] > 0)});
        checkOutput($sformatf("dut%0d done", k), {63'b0, oDone[k]}, {63'b0, mDone[k]});
        checkOutput($sformatf("dut%0d product", k), (k == 0) ? prod0 : prod1, mProd[k]);
      end
    end
  end

  task automatic waitDone(input int k, output int n);
    n = 0;
    do begin
      @(posedge Clock);
      n++;
      #1;
    end while (!oDone[k] && n < 100);
  endtask

  task automatic releaseAck(input int k, input int hold);
    repeat (hold) @(negedge Clock);
    @(negedge Clock);
    iAck[k] = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    iAck[k] = 1'b0;
  endtask

  task automatic applyStimulus(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, input int hold,
                               output int lat, output logic [2*W-1:0] prod);
    @(negedge Clock);
    iData_A   = a;
    iData_B   = b;
    iSigned   = s;
    iValid[k] = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    iValid[k] = 1'b0;
    waitDone(k, lat);
    prod = (k == 0) ? prod0 : prod1;
    releaseAck(k, hold);
  endtask

  task automatic directed(input string name, input int k, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s, input int hold,
                          input logic [2*W-1:0] expProd, input int expLat);
    int lat;
    logic [2*W-1:0] prod;
    applyStimulus(k, a, b, s, hold, lat, prod);
    checkOutput({name, " product"}, prod, expProd);
    checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
  endtask

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return $urandom & 32'hFF;
      default: return $urandom;
    endcase
  endfunction

  // Directed corner cases, handshake and reset scenarios, then randomised operands
  initial begin
    int lat;
    logic [2*W-1:0] prod;
    Reset   = 1'b1;
    iValid  = '0;
    iAck    = '0;
    iSigned = 1'b0;
    iData_A = '0;
    iData_B = '0;
    #2;
    checkOutput("reset busy", {62'b0, oBusy}, 64'h0);
    checkOutput("reset done", {62'b0, oDone}, 64'h0);
    checkOutput("reset prod0", prod0, 64'h0);
    checkOutput("reset prod1", prod1, 64'h0);
    @(negedge Clock);
    #2 Reset = 1'b0;

    directed("umax", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 10, 64'hFFFF_FFFE_0000_0001, 33);
    directed("s m1*m1", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 64'h1, 33);
    directed("s min*min", 0, 32'h8000_0000, 32'h8000_0000, 1'b1, 2, 64'h4000_0000_0000_0000, 33);
    directed("s min*1", 0, 32'h8000_0000, 32'h1, 1'b1, 0, 64'hFFFF_FFFF_8000_0000, 33);
    directed("ee b0", 1, 32'h1234_5678, 32'h0, 1'b0, 0, 64'h0, 2);
    directed("ee b5", 1, 32'h1234_5678, 32'h5, 1'b0, 3, 64'h0000_0000_5B05_B058, 4);
    directed("ee s min*1", 1, 32'h8000_0000, 32'h1, 1'b1, 0, 64'hFFFF_FFFF_8000_0000, 2);
    directed("ee s 3*-3", 1, 32'h3, 32'hFFFF_FFFD, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFF7, 3);
    directed("ee b msb", 1, 32'h1, 32'h8000_0000, 1'b0, 0, 64'h8000_0000, 33);

    // A second operand pair offered mid-calculation must be dropped
    @(negedge Clock);
    iData_A = 32'd3; iData_B = 32'd5; iSigned = 1'b0; iValid[0] = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    iValid[0] = 1'b0;
    repeat (5) @(negedge Clock);
    iData_A = 32'd100; iData_B = 32'd200; iValid[0] = 1'b1;
    @(negedge Clock);
    iValid[0] = 1'b0;
    waitDone(0, lat);
    checkOutput("busy drop product", prod0, 64'd15);
    releaseAck(0, 0);

    // Ack and valid together in DONE only return to IDLE; the held valid is taken one edge later
    @(negedge Clock);
    iData_A = 32'd9; iData_B = 32'd9; iSigned = 1'b0; iValid[1] = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    iValid[1] = 1'b0;
    waitDone(1, lat);
    @(negedge Clock);
    iData_A = 32'd2; iData_B = 32'd3; iAck[1] = 1'b1; iValid[1] = 1'b1;
    @(posedge Clock);
    #1;
    checkOutput("ack+valid busy", {63'b0, oBusy[1]}, 64'h0);
    checkOutput("ack+valid done", {63'b0, oDone[1]}, 64'h0);
    @(negedge Clock);
    iAck[1] = 1'b0;
    @(posedge Clock);
    #1;
    checkOutput("late accept busy", {63'b0, oBusy[1]}, 64'h1);
    @(negedge Clock);
    iValid[1] = 1'b0;
    waitDone(1, lat);
    checkOutput("late accept product", prod1, 64'd6);
    releaseAck(1, 0);

    // Asynchronous reset at iteration 10 clears everything before the next edge
    @(negedge Clock);
    iData_A = 32'hFFFF_FFFF; iData_B = 32'hFFFF_FFFF; iSigned = 1'b0; iValid[0] = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    iValid[0] = 1'b0;
    repeat (10) @(posedge Clock);
    #2 Reset = 1'b1;
    #1;
    checkOutput("async reset busy", {63'b0, oBusy[0]}, 64'h0);
    checkOutput("async reset done", {63'b0, oDone[0]}, 64'h0);
    checkOutput("async reset prod0", prod0, 64'h0);
    checkOutput("async reset prod1", prod1, 64'h0);
    @(negedge Clock);
    #2 Reset = 1'b0;
    directed("after reset 7x6", 0, 32'd7, 32'd6, 1'b0, 0, 64'd42, 33);

    for (int i = 0; i < 1000; i++) begin
      applyStimulus(i % 2, pickOperand(), pickOperand(), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), lat, prod);
    end

    repeat (2) @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so a stuck handshake cannot hang the run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
